// File: rtl/pc_update_unit.sv
// Purpose: program-counter stage; holds the PC, offers PC+4, selects the next PC (jump/beq/bne/+4).
// Latency: a redirect sampled at edge n is visible on pc_o right after that edge; one instruction per cycle.
// Backpressure: busywait_i=1 at an edge freezes the PC and counts stall cycles; redirects apply at the exit edge.
//
// Ports:
//   clk_i, rst_n_i                 clock and asynchronous active-low reset
//   target_addr_i                  branch/jump target from the target-address adder
//   jump_i, branch_i, bne_i, zero_i  redirect controls and ALU zero flag
//   busywait_i                     memory stall request
//   pc_o, pc_plus4_o               current PC (registered) and PC+4 (combinational)
//   imem_read_o                    instruction fetch request (registered)
//   stall_cnt_o                    saturating length of the current/most recent stall
// Build option: define BNE_EN to let bne_i take part in next-PC selection.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          STALL_CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [31:0]            target_addr_i,
  input  logic                   jump_i,
  input  logic                   branch_i,
  input  logic                   bne_i,
  input  logic                   zero_i,
  input  logic                   busywait_i,
  output logic [31:0]            pc_o,
  output logic [31:0]            pc_plus4_o,
  output logic                   imem_read_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic                   imem_read_q, imem_read_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] next_pc;

  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
  assign pc_plus4 = pc_q + 32'd4;

  // jump, beq and (optionally) bne all share the single target address,
  // so priority only matters for deciding whether to redirect at all.
`ifdef BNE_EN
  assign redirect = jump_i | (branch_i & zero_i) | (bne_i & ~zero_i);
`else
  logic unused_bne;
  assign unused_bne = bne_i;
  assign redirect   = jump_i | (branch_i & zero_i);
`endif

  assign next_pc = redirect ? target_addr_i : pc_plus4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      S_BOOT: begin
        // One fetch cycle at RESET_PC before the PC starts advancing.
        state_d = S_RUN;
      end
      S_RUN: begin
        if (busywait_i) begin
          state_d     = S_STALL;
          stall_cnt_d = STALL_CNT_W'(1);
        end else begin
          pc_d = next_pc;
        end
      end
      S_STALL: begin
        if (busywait_i) begin
          if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
          end
        end else begin
          // Redirect inputs are taken as they stand at the exit edge.
          state_d = S_RUN;
          pc_d    = next_pc;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    // Fetch is requested in every state except BOOT.
    imem_read_d = (state_d != S_BOOT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      imem_read_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_read_q <= imem_read_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_plus4;
  assign imem_read_o = imem_read_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Program-counter stage of the 8-bit single-cycle processor. It holds the 32-bit PC and presents it to instruction memory. It computes PC+4 and takes the branch/jump target produced by the target-address adder (PC + sign-extended OFFSET×4). Each cycle it selects the next PC, and it freezes the PC while memory asserts BUSYWAIT.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- STALL_CNT_W, 8, width of the saturating stall counter.

Ports:
- CLK  input  1  processor clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- TARGET_ADDR  input  32  branch/jump target from the target-address adder; valid #2 after PC changes.
- JUMP  input  1  unconditional redirect (j).
- BRANCH  input  1  branch-if-equal (beq).
- BNE  input  1  branch-if-not-equal; honoured only with BNE_EN.
- ZERO  input  1  ALU zero flag of the current instruction.
- BUSYWAIT  input  1  OR of instruction- and data-memory busywait; 1 = stall.
- PC  output  32  current PC, registered.
- PC_PLUS4  output  32  PC + 4, combinational.
- IMEM_READ  output  1  instruction fetch request, registered.
- STALL_CNT  output  STALL_CNT_W  length in cycles of the current or most recent stall.

## Operation
- FSM states: BOOT, RUN, STALL.
- Reset (RESET_N=0, asynchronous) forces the following values:
  - state = BOOT
  - PC = RESET_PC
  - IMEM_READ = 0
  - STALL_CNT = 0
- BOOT: on the first rising edge with RESET_N=1, go to RUN, set IMEM_READ=1, hold PC. This gives one fetch cycle at RESET_PC.
- RUN:
  - Edge with BUSYWAIT=1: go to STALL, hold PC, set STALL_CNT=1.
  - Edge with BUSYWAIT=0: PC ← NEXT_PC.
- STALL:
  - Edge with BUSYWAIT=1: hold PC, STALL_CNT ← STALL_CNT+1, saturating at all-ones.
  - Edge with BUSYWAIT=0: go to RUN, PC ← NEXT_PC (from inputs at that edge), STALL_CNT held.
- IMEM_READ stays 1 in RUN and STALL. It is 0 only in reset and BOOT.
- NEXT_PC priority:
  1. JUMP=1 → TARGET_ADDR.
  2. BRANCH=1 and ZERO=1 → TARGET_ADDR.
  3. BNE=1 and ZERO=0 (BNE_EN only) → TARGET_ADDR.
  4. Otherwise → PC_PLUS4.
- JUMP and BRANCH asserted together: JUMP wins. The result is identical because the target is the same.
- Arithmetic is unsigned 32-bit modulo 2^32. PC=32'hFFFF_FFFC gives PC_PLUS4=0.
- A negative offset is already folded into TARGET_ADDR by the upstream adder. No range check is made here.
- Redirect inputs are sampled only at a non-stalled edge. Inputs that change during STALL take effect only at the exit edge.
- Reset asserted mid-stall or mid-branch: immediate return to reset values, with no pending redirect retained.

## Timing
- PC register update: #1 after rising edge.
- PC_PLUS4 adder: #1 after PC changes.
- NEXT_PC mux: #1.
- The worst redirect path, PC → TARGET_ADDR (#2) → mux (#1), settles 4 time units after the edge. It must meet the 8-unit clock period.
- Latency: a redirect decided in cycle n is visible on PC #1 after edge n+1. With no stalls the instruction rate is one per cycle.
- BUSYWAIT is sampled at the rising edge only. Glitches between edges are ignored.
- STALL_CNT and IMEM_READ update #1 after the edge, together with PC.

## Configuration
- BNE_EN defined: BNE participates in NEXT_PC selection at priority 3.
- BNE_EN undefined: the BNE port remains but is ignored, and beq/j behaviour is unchanged.

## Test plan
- Reset/boot:
  - Stimulus: RESET_N=0, then release; BUSYWAIT=0, no redirect.
  - Required response: PC=0 and IMEM_READ=0 in reset. After the first edge PC=0 and IMEM_READ=1. Subsequent edges give PC=4, 8, 12.
- Taken/untaken beq:
  - Stimulus: PC=8, BRANCH=1, ZERO=1, TARGET_ADDR=32'h18 → next PC=32'h18.
  - Stimulus: same with ZERO=0 → next PC=12.
- Jump and backward branch:
  - Stimulus: PC=32'h20, JUMP=1, TARGET_ADDR=32'h10 → next PC=32'h10.
  - Stimulus: JUMP=1 and BRANCH=1 together → still 32'h10.
- Stall:
  - Stimulus: BUSYWAIT=1 for 3 edges at PC=12, JUMP=1, TARGET_ADDR=32'h40.
  - Required response: PC holds 12 with STALL_CNT=1, 2, 3. At the first edge with BUSYWAIT=0, PC=32'h40 and STALL_CNT stays 3.
- Wrap and saturation:
  - Stimulus: PC=32'hFFFF_FFFC, no redirect → next PC=0.
  - Stimulus: BUSYWAIT=1 for 300 edges → STALL_CNT saturates at 255.
- BNE_EN and async reset:
  - Stimulus: BNE=1, ZERO=0, TARGET_ADDR=32'h30 → 32'h30 with BNE_EN; PC+4 without it.
  - Stimulus: RESET_N pulsed low mid-stall → PC=0 and state BOOT immediately, without waiting for a clock edge.
